// File: rtl/jstk_spi_reader_pkg.sv
// Shared constants for the PmodJSTK reader: FSM encoding,
// command framing and the mapping of received slots onto fields.
package jstk_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [5:0] CMD_PREFIX = 6'b100000;
   localparam int NUM_BYTES = 5;

   localparam int X_LO_SLOT = 0;
   localparam int X_HI_SLOT = 1;
   localparam int Y_LO_SLOT = 2;
   localparam int Y_HI_SLOT = 3;
   localparam int BTN_SLOT  = 4;

   function automatic logic [7:0] tx_byte(
      input logic [2:0] idx,
      input logic [1:0] led
   );
      return (idx == 3'd0) ? {CMD_PREFIX, led} : 8'h00;
   endfunction

endpackage

// File: rtl/jstk_spi_reader_if.sv
// SPI bus between the joystick reader (master) and the PmodJSTK.
interface jstk_spi_reader_if;

   logic ss;
   logic sclk;
   logic mosi;
   logic miso;

   modport master (output ss, output sclk, output mosi, input miso);
   modport slave  (input ss, input sclk, input mosi, output miso);

endinterface

// File: rtl/jstk_spi_reader_shifter.sv
// Single-byte SPI mode-0 engine: MSB first, sclk low then high
// for HALF_DIV cycles each, miso taken on the sclk rising cycle.
module spi_byte_shifter #(
   parameter int HALF_DIV = 750
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [7:0] tx_i,
   input  logic       miso_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic [7:0] rx_o,
   output logic       done_o
);

   localparam logic [15:0] HALF = 16'(HALF_DIV);
   localparam logic [15:0] LAST = 16'(2 * HALF_DIV - 1);

   logic        act_q, act_d;
   logic [2:0]  bit_q, bit_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  rx_q, rx_d;
   logic        rise, last;

   assign rise = act_q && (cnt_q == HALF);
   assign last = act_q && (cnt_q == LAST);

   always_comb begin
      act_d = act_q;
      bit_d = bit_q;
      cnt_d = cnt_q;
      sh_d  = sh_q;
      rx_d  = rx_q;
      if (load_i) begin
         act_d = 1'b1;
         bit_d = 3'd0;
         cnt_d = 16'd0;
         sh_d  = tx_i;
      end else if (act_q) begin
         if (rise) rx_d = {rx_q[6:0], miso_i};
         if (last) begin
            cnt_d = 16'd0;
            if (bit_q == 3'd7) begin
               act_d = 1'b0;
            end else begin
               bit_d = bit_q + 3'd1;
               sh_d  = {sh_q[6:0], 1'b0};
            end
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_q <= 1'b0;
         bit_q <= 3'd0;
         cnt_q <= 16'd0;
         sh_q  <= 8'h00;
         rx_q  <= 8'h00;
      end else begin
         act_q <= act_d;
         bit_q <= bit_d;
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
         rx_q  <= rx_d;
      end
   end

   assign sclk_o = act_q && (cnt_q >= HALF);
   assign mosi_o = act_q & sh_q[7];
   assign rx_o   = rx_q;
   assign done_o = last && (bit_q == 3'd7);

endmodule

// File: rtl/jstk_spi_reader.sv
// PmodJSTK reader: one 5-byte SPI transaction per sample_clk rise,
// publishing X/Y/buttons with a one-cycle data_valid pulse.
module jstk_spi_reader
   import jstk_pkg::*;
#(
   parameter int HALF_DIV  = 750,
   parameter int SS_DELAY  = 1500,
   parameter int GAP_DELAY = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_clk,
   input  logic [1:0]                led,
   jstk_spi_reader_if.master         spi,
   output logic [9:0]                x_pos,
   output logic [9:0]                y_pos,
   output logic [2:0]                buttons,
   output logic                      data_valid,
   output logic                      busy
);

   localparam logic [15:0] SS_LAST  = 16'(SS_DELAY - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_DELAY - 1);
   localparam logic [2:0]  IDX_LAST = 3'(NUM_BYTES - 1);

   logic [2:0]  st_q, st_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [1:0]  led_q, led_d;
   logic        sc_q;
   logic        ss_q, ss_d;
   logic        busy_q, busy_d;
   logic        dv_q, dv_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [2:0]  btn_q, btn_d;
   logic [NUM_BYTES-2:0][7:0] slot_q, slot_d;

   logic        load;
   logic [7:0]  tx;
   logic [7:0]  rx;
   logic        sh_done;

   spi_byte_shifter #(
      .HALF_DIV (HALF_DIV)
   ) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .tx_i   (tx),
      .miso_i (spi.miso),
      .sclk_o (spi.sclk),
      .mosi_o (spi.mosi),
      .rx_o   (rx),
      .done_o (sh_done)
   );

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      led_d  = led_q;
      ss_d   = ss_q;
      busy_d = busy_q;
      dv_d   = 1'b0;
      x_d    = x_q;
      y_d    = y_q;
      btn_d  = btn_q;
      slot_d = slot_q;
      load   = 1'b0;
      tx     = 8'h00;
      unique case (st_q)
         ST_IDLE: begin
            // rises arriving in any other state are simply dropped
            if (sample_clk && !sc_q) begin
               st_d   = ST_SETUP;
               cnt_d  = 16'd0;
               idx_d  = 3'd0;
               led_d  = led;
               ss_d   = 1'b0;
               busy_d = 1'b1;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SS_LAST) begin
               cnt_d = 16'd0;
               load  = 1'b1;
               tx    = tx_byte(idx_q, led_q);
               st_d  = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SHIFT: begin
            if (sh_done) begin
               if (idx_q == IDX_LAST) begin
                  st_d  = ST_DONE;
                  ss_d  = 1'b1;
                  dv_d  = 1'b1;
                  x_d   = {slot_q[X_HI_SLOT][1:0], slot_q[X_LO_SLOT]};
                  y_d   = {slot_q[Y_HI_SLOT][1:0], slot_q[Y_LO_SLOT]};
                  btn_d = rx[2:0];
               end else begin
                  slot_d[idx_q[1:0]] = rx;
                  st_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = 16'd0;
               idx_d = idx_q + 3'd1;
               load  = 1'b1;
               tx    = tx_byte(idx_q + 3'd1, led_q);
               st_d  = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            st_d   = ST_IDLE;
            busy_d = 1'b0;
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= ST_IDLE;
         cnt_q  <= 16'd0;
         idx_q  <= 3'd0;
         led_q  <= 2'b00;
         sc_q   <= 1'b0;
         ss_q   <= 1'b1;
         busy_q <= 1'b0;
         dv_q   <= 1'b0;
         x_q    <= 10'd0;
         y_q    <= 10'd0;
         btn_q  <= 3'd0;
         slot_q <= '0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         led_q  <= led_d;
         sc_q   <= sample_clk;
         ss_q   <= ss_d;
         busy_q <= busy_d;
         dv_q   <= dv_d;
         x_q    <= x_d;
         y_q    <= y_d;
         btn_q  <= btn_d;
         slot_q <= slot_d;
      end
   end

   assign spi.ss     = ss_q;
   assign x_pos      = x_q;
   assign y_pos      = y_q;
   assign buttons    = btn_q;
   assign data_valid = dv_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Self-checking bench: a PmodJSTK slave model plus a spec-level
// reference for command bytes, field packing, latency and SCLK timing.
module tb_jstk_spi_reader;

   localparam int H = 2;
   localparam int S = 4;
   localparam int G = 3;
   localparam int LAT = 1 + S + 80 * H + 4 * G;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_clk;
   logic [1:0] led;
   logic [9:0] x_pos, y_pos;
   logic [2:0] buttons;
   logic       data_valid, busy;

   jstk_spi_reader_if spi ();

   jstk_spi_reader #(
      .HALF_DIV  (H),
      .SS_DELAY  (S),
      .GAP_DELAY (G)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_clk (sample_clk),
      .led        (led),
      .spi        (spi.master),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .buttons    (buttons),
      .data_valid (data_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] resp [5];
   logic [7:0] tx_got [5];
   int   rise_cnt, low_run, high_run, dv_cnt, ss_falls;
   logic prev_sclk, prev_ss, prev_mosi, mosi_rise;

   function automatic int exp_low(input int r);
      if (r == 0) return S + H;
      if (r % 8 == 0) return G + H;
      return H;
   endfunction

   // slave model and bus monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         prev_sclk = 1'b0;
         prev_ss   = 1'b1;
         prev_mosi = 1'b0;
         rise_cnt  = 0;
         low_run   = 0;
         high_run  = 0;
         spi.miso  = 1'b0;
      end else begin
         if (data_valid) dv_cnt++;
         if (!spi.ss && prev_ss) begin
            ss_falls++;
            rise_cnt = 0;
            low_run  = 0;
            for (int i = 0; i < 5; i++) tx_got[i] = 8'h00;
            spi.miso = resp[0][7];
         end
         if (!spi.ss) begin
            if (spi.sclk && !prev_sclk) begin
               chk("sclk_low", low_run, exp_low(rise_cnt));
               chk("mosi_setup", spi.mosi, prev_mosi);
               mosi_rise = spi.mosi;
               if (rise_cnt < 40)
                  tx_got[rise_cnt / 8] = {tx_got[rise_cnt / 8][6:0], spi.mosi};
               rise_cnt++;
               high_run = 1;
            end else if (spi.sclk) begin
               high_run++;
               chk("mosi_hold", spi.mosi, mosi_rise);
            end else if (prev_sclk) begin
               chk("sclk_high", high_run, H);
               low_run = 1;
               if (rise_cnt < 40) begin
                  logic [7:0] b;
                  b = resp[rise_cnt / 8];
                  spi.miso = b[7 - rise_cnt % 8];
               end
            end else begin
               low_run++;
            end
         end
         prev_sclk = spi.sclk;
         prev_ss   = spi.ss;
         prev_mosi = spi.mosi;
      end
   end

   task automatic txn(input logic [1:0] l, input int mode);
      int  k;
      bit  got;
      int  ex, ey, eb;
      ex = (int'(resp[1]) % 4) * 256 + int'(resp[0]);
      ey = (int'(resp[3]) % 4) * 256 + int'(resp[2]);
      eb = int'(resp[4]) % 8;
      dv_cnt   = 0;
      ss_falls = 0;
      @(negedge clk);
      led = l;
      sample_clk = 1'b1;
      @(posedge clk);
      k = 0;
      got = 0;
      while (!got && k < 400) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            chk("ss_fall", spi.ss, 1'b0);
            chk("busy_rise", busy, 1'b1);
         end
         if (k == 3) sample_clk = 1'b0;
         if (mode == 1 && k == 40) sample_clk = 1'b1;
         if (mode == 1 && k == 44) sample_clk = 1'b0;
         if (data_valid) begin
            got = 1;
            chk("dv_latency", k, LAT);
            chk("ss_at_dv", spi.ss, 1'b1);
            chk("x_pos", x_pos, ex);
            chk("y_pos", y_pos, ey);
            chk("buttons", buttons, eb);
         end
      end
      if (!got) chk("dv_timeout", 0, 1);
      @(negedge clk);
      chk("dv_pulse", data_valid, 1'b0);
      chk("busy_fall", busy, 1'b0);
      chk("sclk_rises", rise_cnt, 40);
      chk("tx_byte0", tx_got[0], 32'h80 + 32'(l));
      for (int i = 1; i < 5; i++) chk("tx_byte", tx_got[i], 0);
      if (mode == 1) begin
         repeat (LAT + 20) @(negedge clk);
         chk("dv_count", dv_cnt, 1);
         chk("ss_falls", ss_falls, 1);
      end
   endtask

   task automatic rand_resp();
      for (int i = 0; i < 5; i++) resp[i] = 8'($urandom);
   endtask

   initial begin
      rst = 1'b0;
      sample_clk = 1'b0;
      led = 2'b00;
      for (int i = 0; i < 5; i++) resp[i] = 8'h00;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sample_clk = ~sample_clk;
         chk("rst_ss", spi.ss, 1'b1);
         chk("rst_sclk", spi.sclk, 1'b0);
         chk("rst_dv", data_valid, 1'b0);
      end
      chk("rst_mosi", spi.mosi, 1'b0);
      chk("rst_x", x_pos, 0);
      chk("rst_y", y_pos, 0);
      chk("rst_btn", buttons, 0);
      chk("rst_busy", busy, 1'b0);
      sample_clk = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      resp[0] = 8'h5A; resp[1] = 8'h03; resp[2] = 8'hC4;
      resp[3] = 8'h01; resp[4] = 8'h05;
      txn(2'b10, 0);
      chk("single_x", x_pos, 10'h35A);
      chk("single_y", y_pos, 10'h1C4);
      chk("single_btn", buttons, 3'b101);

      rand_resp();
      txn(2'($urandom), 1);

      rand_resp();
      @(negedge clk);
      sample_clk = 1'b1;
      repeat (84) @(negedge clk);
      sample_clk = 1'b0;
      chk("abort_in_byte2", rise_cnt / 8, 2);
      #2 rst = 1'b0;
      #1;
      chk("abort_ss", spi.ss, 1'b1);
      chk("abort_sclk", spi.sclk, 1'b0);
      chk("abort_mosi", spi.mosi, 1'b0);
      chk("abort_x", x_pos, 0);
      chk("abort_y", y_pos, 0);
      chk("abort_btn", buttons, 0);
      chk("abort_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      txn(2'($urandom), 0);

      for (int i = 0; i < 5; i++) resp[i] = 8'hFF;
      txn(2'b01, 0);
      chk("ff_x", x_pos, 10'h3FF);
      chk("ff_y", y_pos, 10'h3FF);
      chk("ff_btn", buttons, 3'b111);

      for (int n = 0; n < 5; n++) begin
         rand_resp();
         txn(2'($urandom), 0);
         repeat (int'($urandom_range(0, 5))) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
